// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 select datapath among four requesters.
// Optional build macro MUX4_RR_ARBITER_FIXED_PRIO_EN switches to fixed priority (req[0] highest).
module mux4_rr_arbiter #(
    parameter int DATA_W   = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t            state;
    state_t            state_d;
    logic [3:0]        hold_cnt;
    logic [3:0]        hold_d;
    logic [3:0]        gnt_d;
    logic [1:0]        sel_d;
    logic [DATA_W-1:0] dout_d;
    logic              valid_d;
    logic [DATA_W-1:0] din_mux;
    logic [1:0]        scan_start;
    logic              win_found;
    logic [1:0]        win_idx;
    logic              release_grant;

`ifndef MUX4_RR_ARBITER_FIXED_PRIO_EN
    logic [1:0]        ptr;
    logic [1:0]        ptr_d;
`endif

    always_comb begin
        case (sel)
            2'd0:    din_mux = din0;
            2'd1:    din_mux = din1;
            2'd2:    din_mux = din2;
            default: din_mux = din3;
        endcase
    end

    // A grant ends when its owner drops req or has used up its tenure.
    assign release_grant = (state == GRANT) && (!req[sel] || (hold_cnt == HOLD_MAX));

`ifdef MUX4_RR_ARBITER_FIXED_PRIO_EN
    assign scan_start = 2'd0;
`else
    // On release the scan starts just past the outgoing owner, giving it lowest priority.
    assign scan_start = (state == GRANT) ? sel + 2'd1 : ptr;
`endif

    // First set request bit found walking upward from scan_start, wrapping mod 4.
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = scan_start + 2'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state always uses non-blocking assignment so every register samples pre-edge values.
            state <= state_d;
        end
    end

    // Next-state and grant bookkeeping
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        state_d = state;
        hold_d  = hold_cnt;
        gnt_d   = gnt;
        sel_d   = sel;
`ifndef MUX4_RR_ARBITER_FIXED_PRIO_EN
        ptr_d   = ptr;
`endif
        case (state)
            IDLE: begin
                gnt_d = 4'b0000;
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    hold_d  = 4'd1;
                end
            end
            GRANT: begin
                if (release_grant) begin
`ifndef MUX4_RR_ARBITER_FIXED_PRIO_EN
                    ptr_d = sel + 2'd1;
`endif
                    if (win_found) begin
                        gnt_d  = 4'b0001 << win_idx;
                        sel_d  = win_idx;
                        hold_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = 4'd0;
                    end
                end else begin
                    hold_d = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // Output logic: capture only when the granted requester is still asking.
    always_comb begin
        dout_d  = dout;
        valid_d = 1'b0;
        if ((state == GRANT) && req[sel]) begin
            dout_d  = din_mux;
            valid_d = 1'b1;
        end
    end

    assign busy = (state == GRANT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            hold_cnt   <= 4'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
`ifndef MUX4_RR_ARBITER_FIXED_PRIO_EN
            ptr        <= 2'd0;
`endif
        end else begin
            gnt        <= gnt_d;
            sel        <= sel_d;
            hold_cnt   <= hold_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
`ifndef MUX4_RR_ARBITER_FIXED_PRIO_EN
            ptr        <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a cycle-level reference model predicts grants
// and queues expected captured words; a negedge monitor pops and compares them.
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 2;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [DATA_W-1:0] din0, din1, din2, din3;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    int                n_cmp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    // Reference model: who owns the datapath, for how long, and where the next scan begins.
    int m_busy, m_owner, m_hold, m_ptr;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    function automatic int scan_from(input int after_owner);
`ifdef MUX4_RR_ARBITER_FIXED_PRIO_EN
        return 0;
`else
        return after_owner;
`endif
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_hold  = 0;
        m_ptr   = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [DATA_W-1:0] d[4];
        int w;
        d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3;
        if (m_busy == 0) begin
            w = pick(req, scan_from(m_ptr));
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_hold  = 1;
            end
        end else begin
            if (req[m_owner]) exp_q.push_back(d[m_owner]);
            if (!req[m_owner] || m_hold == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 4;
                w = pick(req, scan_from(m_ptr));
                if (w >= 0) begin
                    m_owner = w;
                    m_hold  = 1;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_state();
        check("gnt",  32'(gnt),  (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
        check("sel",  32'(sel),  32'(m_owner));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    // Called at a negedge: drive one cycle of stimulus, let an edge pass, check at the next negedge.
    task automatic cycle(input logic [3:0] r, input bit fix_din1, input logic [DATA_W-1:0] d1);
        req  = r;
        din0 = DATA_W'($urandom);
        din1 = fix_din1 ? d1 : DATA_W'($urandom);
        din2 = DATA_W'($urandom);
        din3 = DATA_W'($urandom);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 1'b0, '0);
    endtask

    // Monitor: every captured word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            if (exp_q.size() == 0) check("valid_unexpected", 32'(dout_valid), 32'd0);
            else                   check("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt",   32'(gnt),        32'd0);
        check("rst_sel",   32'(sel),        32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        rst = 1'b0;

        // Reset in the middle of a grant to requester 2
        cycle(4'b0100, 1'b0, '0);
        req  = 4'b0100;
        din2 = 2'b11;
        model_step();
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_gnt",   32'(gnt),        32'd0);
        check("midrst_busy",  32'(busy),       32'd0);
        check("midrst_dout",  32'(dout),       32'd0);
        check("midrst_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0001, 1'b0, '0);
        cycle(4'b0001, 1'b0, '0);
        idle_cycles(2);

        // Single burst from requester 1
        cycle(4'b0010, 1'b1, 2'b01);
        cycle(4'b0010, 1'b1, 2'b01);
        cycle(4'b0010, 1'b1, 2'b10);
        cycle(4'b0010, 1'b1, 2'b11);
        idle_cycles(3);

        // Hold expiry alternation between requesters 0 and 2
        for (int i = 0; i < 12; i++) cycle(4'b0101, 1'b0, '0);
        idle_cycles(2);

        // Full contention rotation
        for (int i = 0; i < 32; i++) cycle(4'b1111, 1'b0, '0);
        idle_cycles(2);

        // Sole requester re-granted across tenure expiries
        for (int i = 0; i < 10; i++) cycle(4'b1000, 1'b0, '0);
        idle_cycles(2);

        // Requesters 0 and 3 competing, then requester 0 leaves
        for (int i = 0; i < 12; i++) cycle(4'b1001, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b0, '0);
        idle_cycles(2);

        // Random traffic with requests rising and dropping freely
        for (int i = 0; i < 400; i++) cycle(4'($urandom), 1'b0, '0);
        idle_cycles(3);

        check("words_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
